sram_pattern_tester: RTL and testbench



---
 rtl/sram_pattern_tester_if.sv | 21 ++
 rtl/sram_pattern_tester.sv | 233 +++++++++++++++++++++++
 tb/tb_sram_pattern_tester.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/sram_pattern_tester_if.sv
// ---------------------------------------------------------------------------
// sram_pattern_tester_if
// Bus between the pattern tester and the basic SRAM controller.
//   rw         : 1 = read/idle, 0 = write            (tester -> controller)
//   addr       : SRAM address                        (tester -> controller)
//   data_f2s   : write data                          (tester -> controller)
//   data_s2f_r : registered read data                (controller -> tester)
// Modports: master = tester side, slave = controller side.
// ---------------------------------------------------------------------------
interface sram_pattern_tester_if #(
    parameter int ADDR_W = 19,
    parameter int DATA_W = 8
);
    logic              rw;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data_f2s;
    logic [DATA_W-1:0] data_s2f_r;

    modport master (output rw, output addr, output data_f2s, input data_s2f_r);
    modport slave  (input rw, input addr, input data_f2s, output data_s2f_r);
endinterface

// File: rtl/sram_pattern_tester.sv
// ---------------------------------------------------------------------------
// sram_pattern_tester
// Writes exp(a) = a[7:0] ^ a[15:8] ^ SEED to every address 0..LAST_ADDR
// through the SRAM controller, reads every location back and compares.
// Reports busy/done/pass, a saturating error count and the first failing
// address. All outputs are registered.
//
// Ports:
//   clk            : system clock
//   reset          : synchronous, active-high reset
//   start          : one-cycle run request, ignored while busy
//   bus            : controller bus (master modport: rw, addr, data_f2s out;
//                    data_s2f_r in)
//   busy           : run in progress
//   done           : run finished, held until next accepted start or reset
//   pass           : valid with done, 1 when err_count is zero
//   err_count      : number of mismatches, saturating
//   first_err_addr : address of the first mismatch (0 if none)
//
// Optional feature macro: SRAM_TESTER_INV_PASS_EN
//   When defined, a second write+read pass with inverted data follows the
//   first; errors accumulate across both passes.
// ---------------------------------------------------------------------------
module sram_pattern_tester #(
    parameter int                ADDR_W    = 19,
    parameter int                DATA_W    = 8,
    parameter logic [ADDR_W-1:0] LAST_ADDR = 19'h7FFFF,
    parameter logic [7:0]        SEED      = 8'hA5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    sram_pattern_tester_if.master bus,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [ADDR_W:0]       err_count,
    output logic [ADDR_W-1:0]     first_err_addr
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        W_SETUP = 3'd1,
        W_PULSE = 3'd2,
        W_HOLD  = 3'd3,
        R_ADDR  = 3'd4,
        R_CHECK = 3'd5,
        FIN     = 3'd6
    } state_t;

    localparam logic [ADDR_W-1:0] ONE_A = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W:0]   ONE_E = {{ADDR_W{1'b0}}, 1'b1};

    // Pattern for address a; inv selects the bit-inverted pass.
    function automatic logic [DATA_W-1:0] pattern(input logic [ADDR_W-1:0] a,
                                                  input logic              inv);
        logic [ADDR_W+15:0] ax;
        logic [DATA_W+7:0]  xe;
        ax = {16'h0000, a};
        xe = {{DATA_W{1'b0}}, (ax[7:0] ^ ax[15:8] ^ SEED)};
        return xe[DATA_W-1:0] ^ {DATA_W{inv}};
    endfunction

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   a_q, a_d;
    logic                rw_q, rw_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                pass_q, pass_d;
    logic [ADDR_W:0]     err_q, err_d;
    logic [ADDR_W-1:0]   ferr_q, ferr_d;
    logic                inv_s;

`ifdef SRAM_TESTER_INV_PASS_EN
    logic inv_q, inv_d;
    assign inv_s = inv_q;
`else
    assign inv_s = 1'b0;
`endif

    // State and registered-output update, synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            a_q     <= '0;
            rw_q    <= 1'b1;
            addr_q  <= '0;
            data_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            err_q   <= '0;
            ferr_q  <= '0;
`ifdef SRAM_TESTER_INV_PASS_EN
            inv_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            rw_q    <= rw_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            err_q   <= err_d;
            ferr_q  <= ferr_d;
`ifdef SRAM_TESTER_INV_PASS_EN
            inv_q   <= inv_d;
`endif
        end
    end

    // Next-state and next-output logic. addr/data are only moved on cycles
    // where rw stays high, so the pads never see addr and we_n move together.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        rw_d    = rw_q;
        addr_d  = addr_q;
        data_d  = data_q;
        busy_d  = busy_q;
        done_d  = done_q;
        pass_d  = pass_q;
        err_d   = err_q;
        ferr_d  = ferr_q;
`ifdef SRAM_TESTER_INV_PASS_EN
        inv_d   = inv_q;
`endif
        case (state_q)
            IDLE: begin
                rw_d   = 1'b1;
                addr_d = '0;
                if (start) begin
                    err_d   = '0;
                    ferr_d  = '0;
                    done_d  = 1'b0;
                    pass_d  = 1'b0;
                    busy_d  = 1'b1;
                    a_d     = '0;
                    data_d  = pattern('0, 1'b0);
                    state_d = W_SETUP;
`ifdef SRAM_TESTER_INV_PASS_EN
                    inv_d   = 1'b0;
`endif
                end else begin
                    state_d = IDLE;
                end
            end
            W_SETUP: begin
                rw_d    = 1'b0;
                state_d = W_PULSE;
            end
            W_PULSE: begin
                rw_d    = 1'b1;
                state_d = W_HOLD;
            end
            W_HOLD: begin
                if (a_q == LAST_ADDR) begin
                    a_d     = '0;
                    addr_d  = '0;
                    state_d = R_ADDR;
                end else begin
                    a_d     = a_q + ONE_A;
                    addr_d  = a_q + ONE_A;
                    data_d  = pattern(a_q + ONE_A, inv_s);
                    state_d = W_SETUP;
                end
            end
            R_ADDR: begin
                state_d = R_CHECK;
            end
            R_CHECK: begin
                // Read data was captured by the controller at the end of R_ADDR.
                if (bus.data_s2f_r != pattern(a_q, inv_s)) begin
                    if (err_q != {(ADDR_W+1){1'b1}}) begin
                        err_d = err_q + ONE_E;
                    end else begin
                        err_d = err_q;
                    end
                    if (err_q == '0) begin
                        ferr_d = a_q;
                    end else begin
                        ferr_d = ferr_q;
                    end
                end else begin
                    err_d = err_q;
                end
                if (a_q == LAST_ADDR) begin
`ifdef SRAM_TESTER_INV_PASS_EN
                    if (!inv_q) begin
                        inv_d   = 1'b1;
                        a_d     = '0;
                        addr_d  = '0;
                        data_d  = pattern('0, 1'b1);
                        state_d = W_SETUP;
                    end else begin
                        state_d = FIN;
                    end
`else
                    state_d = FIN;
`endif
                end else begin
                    a_d     = a_q + ONE_A;
                    addr_d  = a_q + ONE_A;
                    state_d = R_ADDR;
                end
            end
            FIN: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                pass_d  = (err_q == '0);
                addr_d  = '0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.rw         = rw_q;
    assign bus.addr       = addr_q;
    assign bus.data_f2s   = data_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign pass           = pass_q;
    assign err_count      = err_q;
    assign first_err_addr = ferr_q;

endmodule

// File: tb/tb_sram_pattern_tester.sv
module tb_sram_pattern_tester;
    localparam int ADDR_W = 19;
    localparam int DATA_W = 8;
    localparam int N      = 16;
`ifdef SRAM_TESTER_INV_PASS_EN
    localparam int PASSES = 2;
`else
    localparam int PASSES = 1;
`endif

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic              busy, done, pass;
    logic [ADDR_W:0]   err_count;
    logic [ADDR_W-1:0] first_err_addr;

    sram_pattern_tester_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    sram_pattern_tester #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LAST_ADDR(19'd15), .SEED(8'hA5)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .bus(bus.master),
        .busy(busy), .done(done), .pass(pass),
        .err_count(err_count), .first_err_addr(first_err_addr)
    );

    always #5 clk = ~clk;

    int tests_run = 0;
    int tests_failed = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] expv(input int a);
        logic [31:0] av;
        av = a;
        return av[7:0] ^ av[15:8] ^ 8'hA5;
    endfunction

    // Fault configuration used by the SRAM model.
    logic [7:0] rx [N];
    logic [7:0] stuck0 = 8'h00;
    logic       mon_clr = 1'b0;

    // Behavioural SRAM + controller and write-sequence monitor
    logic [7:0] mem [N];
    int         wr_cnt = 0, wr_bad = 0, glitch = 0, skew = 0;
    logic       prev_rw = 1'b1;
    logic [ADDR_W-1:0] prev_addr = '0;
    logic [7:0] prev_data = 8'h00;

    // Model of the controller: write on rw low, registered read otherwise.
    always @(posedge clk) begin
        if (!bus.rw) mem[bus.addr[3:0]] <= bus.data_f2s;
        bus.data_s2f_r <= (mem[bus.addr[3:0]] & ~stuck0) ^ rx[bus.addr[3:0]];
        prev_rw   <= bus.rw;
        prev_addr <= bus.addr;
        prev_data <= bus.data_f2s;
        if (mon_clr) begin
            wr_cnt <= 0; wr_bad <= 0; glitch <= 0; skew <= 0;
        end else begin
            if (!bus.rw) begin
                wr_cnt <= wr_cnt + 1;
                if (bus.addr != ADDR_W'(wr_cnt % N) ||
                    bus.data_f2s != (expv(wr_cnt % N) ^ (((wr_cnt / N) % 2 == 1) ? 8'hFF : 8'h00)))
                    wr_bad <= wr_bad + 1;
                if (!prev_rw) glitch <= glitch + 1;
            end
            if (bus.rw != prev_rw && (bus.addr != prev_addr || bus.data_f2s != prev_data))
                skew <= skew + 1;
        end
    end

    // Reference: errors and first failing address from the fault setup.
    task automatic model(output int e, output int f);
        logic [7:0] want, got;
        e = 0; f = 0;
        for (int p = 0; p < PASSES; p++) begin
            for (int a = 0; a < N; a++) begin
                want = expv(a) ^ ((p == 1) ? 8'hFF : 8'h00);
                got  = (want & ~stuck0) ^ rx[a];
                if (got != want) begin
                    if (e == 0) f = a;
                    e++;
                end
            end
        end
    endtask

    // Start a run, optionally re-pulse start at edge extra_at, check result.
    task automatic run_check(input string name, input int extra_at);
        int n, e, f;
        bit seen;
        model(e, f);
        @(negedge clk); start = 1'b1; mon_clr = 1'b1;
        @(posedge clk);
        n = 0; seen = 0;
        while (!seen && n < 2000) begin
            @(negedge clk);
            start = (n + 1 == extra_at);
            mon_clr = 1'b0;
            @(posedge clk);
            n++;
            #1;
            if (n == 1) begin
                check_eq({name, "_busy_start"}, {31'd0, busy}, 32'd1);
                check_eq({name, "_done_clr"}, {31'd0, done}, 32'd0);
                check_eq({name, "_err_clr"}, err_count, 32'd0);
            end
            if (done) seen = 1;
        end
        @(negedge clk); start = 1'b0;
        check_eq({name, "_latency"}, n, 5 * N * PASSES + 1);
        check_eq({name, "_err"}, err_count, e);
        check_eq({name, "_first"}, first_err_addr, f);
        check_eq({name, "_pass"}, {31'd0, pass}, (e == 0) ? 32'd1 : 32'd0);
        check_eq({name, "_busy_end"}, {31'd0, busy}, 32'd0);
        check_eq({name, "_writes"}, wr_cnt, N * PASSES);
        check_eq({name, "_wr_bad"}, wr_bad, 0);
        check_eq({name, "_rw_pulse"}, glitch, 0);
        check_eq({name, "_skew"}, skew, 0);
        repeat (3) @(posedge clk);
        #1 check_eq({name, "_done_hold"}, {31'd0, done}, 32'd1);
    endtask

    task automatic check_reset_state(input string name);
        check_eq({name, "_rw"}, {31'd0, bus.rw}, 32'd1);
        check_eq({name, "_addr"}, bus.addr, 32'd0);
        check_eq({name, "_data"}, {24'd0, bus.data_f2s}, 32'd0);
        check_eq({name, "_status"}, {28'd0, busy, done, pass, 1'b0}, 32'd0);
        check_eq({name, "_errs"}, err_count, 32'd0);
        check_eq({name, "_ferr"}, first_err_addr, 32'd0);
    endtask

    task automatic clear_faults();
        for (int i = 0; i < N; i++) rx[i] = 8'h00;
        stuck0 = 8'h00;
    endtask

    initial begin
        int k;
        bit hit;
        clear_faults();
        for (int i = 0; i < N; i++) mem[i] = 8'h00;
        repeat (3) @(posedge clk);
        #1 check_reset_state("por");
        @(negedge clk); reset = 1'b0;

        run_check("clean", 0);

        rx[5] = 8'h01; rx[9] = 8'h40;
        run_check("flip5_9", 37);

        clear_faults(); stuck0 = 8'h08;
        run_check("stuck3", 5 * N * PASSES + 1);

        // Reset in the middle of the write of address 7, with start also high.
        clear_faults();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        hit = 0; k = 0;
        while (!hit && k < 500) begin
            @(posedge clk); #1;
            k++;
            if (!bus.rw && bus.addr == 19'd7) hit = 1;
        end
        check_eq("reach_a7", {31'd0, hit}, 32'd1);
        @(negedge clk); reset = 1'b1; start = 1'b1;
        @(posedge clk); #1 check_reset_state("midrst");
        @(negedge clk); reset = 1'b0; start = 1'b0;
        @(posedge clk); #1 check_eq("midrst_idle", {31'd0, busy}, 32'd0);
        run_check("after_rst", 0);

        for (int r = 0; r < 6; r++) begin
            clear_faults();
            for (int i = 0; i < N; i++)
                if ($urandom_range(0, 3) == 0) rx[i] = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 1) == 1) stuck0 = 8'(1 << $urandom_range(0, 7));
            run_check($sformatf("rand%0d", r), $urandom_range(0, 5 * N * PASSES + 1));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
